// File: rtl/div_sched_ctrl.sv
// div_sched_ctrl: a 50%-duty clock divider whose ratio can be changed at run time.
// A new divisor is loaded through a valid/ready handshake and only takes effect on an
// output-period boundary, so `out` never glitches. A one-cycle period_tick marks the
// first cycle of every output period.
// Optional build macro: ODD_DUTY50_EN adds a falling-edge flop so odd ratios get an
// exact 50% duty cycle.
module div_sched_ctrl #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             busy,
  output logic             period_tick,
  output logic             out
);

  typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_act_q, div_act_d;
  logic [CNT_W-1:0]   div_pend_q, div_pend_d;
  logic               out_pos_q, out_pos_d;
  logic               tick_q, tick_d;
  logic               cfg_err_q, cfg_err_d;

  logic               xfer;
  logic               legal;
  logic               running;
  logic               wrap;

  // Handshake and period-boundary decode from current state.
  always_comb begin
    xfer    = cfg_valid && (state_q != StPend);
    legal   = (cfg_div >= CNT_W'(2));
    running = (state_q != StIdle);
    wrap    = running && (cnt_q == (div_act_q - CNT_W'(1)));
  end

  // State register and all posedge-timed datapath flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_act_q  <= CNT_W'(DEF_DIV);
      div_pend_q <= '0;
      out_pos_q  <= 1'b0;
      tick_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      out_pos_q  <= out_pos_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Next-state logic: period counting, divisor scheduling and sticky error flag.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    cfg_err_d  = cfg_err_q;

    // Every consumed offer updates the error flag; illegal offers change nothing else.
    if (xfer) begin
      cfg_err_d = !legal;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // A divisor loaded on the start edge applies to the very first period.
        if (xfer && legal) begin
          div_act_d = cfg_div;
        end
        if (enable) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (wrap) begin
          cnt_d = '0;
          if (!enable) begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (xfer && legal) begin
          if (wrap && !enable) begin
            // Stopping on this edge: nothing left to wait for, keep it for the next start.
            div_act_d = cfg_div;
          end else begin
            // Even on a wrap edge the new ratio waits for the following wrap.
            div_pend_d = cfg_div;
            state_d    = StPend;
          end
        end
      end

      StPend: begin
        if (wrap) begin
          cnt_d     = '0;
          div_act_d = div_pend_q;
          state_d   = enable ? StRun : StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Output and tick are registered from the next count so they line up with cnt_q.
    out_pos_d = (state_d != StIdle) && (cnt_d < (div_act_d >> 1));
    tick_d    = (state_d != StIdle) && (cnt_d == '0);
  end

`ifdef ODD_DUTY50_EN
  logic out_neg_q, out_neg_d;

  // Half-cycle stretch of the high phase; only odd ratios need it.
  always_comb begin
    out_neg_d = out_pos_q & div_act_q[0];
  end

  // Falling-edge capture of the posedge output.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      out_neg_q <= 1'b0;
    end else begin
      out_neg_q <= out_neg_d;
    end
  end
`endif

  // Output decode from registered state.
  always_comb begin
    cfg_ready   = (state_q != StPend);
    busy        = (state_q != StIdle);
    cfg_err     = cfg_err_q;
    period_tick = tick_q;
`ifdef ODD_DUTY50_EN
    out         = out_pos_q | out_neg_q;
`else
    out         = out_pos_q;
`endif
  end

endmodule

// File: tb/tb_div_sched_ctrl.sv
// Directed testbench for div_sched_ctrl with hand-computed expected waveforms.
module tb_div_sched_ctrl;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             busy;
  logic             period_tick;
  logic             out_s;

  int checks;
  int errors;

  div_sched_ctrl #(
    .CNT_W   (CNT_W),
    .DEF_DIV (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_div     (cfg_div),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .busy        (busy),
    .period_tick (period_tick),
    .out         (out_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles of a period of length div, k0 being the count after the first edge.
  task automatic run_chk(input string tag, input int n, input int div, input int k0,
                         input logic rdy);
    int hi;
    int c;
    hi = div / 2;
`ifdef ODD_DUTY50_EN
    if ((div % 2) == 1) hi = hi + 1;
`endif
    for (int k = k0; k < k0 + n; k++) begin
      step();
      c = k % div;
      check_eq({tag, "_out"},  {31'd0, out_s},       (c < hi) ? 32'd1 : 32'd0);
      check_eq({tag, "_tick"}, {31'd0, period_tick}, (c == 0) ? 32'd1 : 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy},        32'd1);
      check_eq({tag, "_rdy"},  {31'd0, cfg_ready},   {31'd0, rdy});
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;

    // Reset values.
    #2;
    check_eq("rst_out",  {31'd0, out_s},       32'd0);
    check_eq("rst_tick", {31'd0, period_tick}, 32'd0);
    check_eq("rst_busy", {31'd0, busy},        32'd0);
    check_eq("rst_rdy",  {31'd0, cfg_ready},   32'd1);
    check_eq("rst_err",  {31'd0, cfg_err},     32'd0);
    #10;
    reset = 1'b0;
    #1;
    enable = 1'b1;

    // Default ratio 12: 6 high / 6 low.
    run_chk("def12", 28, 12, 0, 1'b1);

    // Offer 80 at cnt=3; current period completes, then 40/40.
    cfg_valid = 1'b1;
    cfg_div   = 8'd80;
    check_eq("cfg80_rdy_pre", {31'd0, cfg_ready}, 32'd1);
    step();
    cfg_valid = 1'b0;
    check_eq("cfg80_rdy_pend", {31'd0, cfg_ready}, 32'd0);
    check_eq("cfg80_out4",     {31'd0, out_s},     32'd1);
    run_chk("tail12", 7, 12, 5, 1'b0);
    run_chk("div80", 81, 80, 0, 1'b1);

    // Schedule 12 during an 80 period, then stop at cnt=2 of the 12 period.
    cfg_valid = 1'b1;
    cfg_div   = 8'd12;
    step();
    cfg_valid = 1'b0;
    check_eq("cfg12_rdy", {31'd0, cfg_ready}, 32'd0);
    check_eq("cfg12_out", {31'd0, out_s},     32'd1);
    run_chk("tail80", 78, 80, 2, 1'b0);
    run_chk("new12", 3, 12, 0, 1'b1);
    enable = 1'b0;
    run_chk("stop12", 9, 12, 3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("idle_out",  {31'd0, out_s},       32'd0);
      check_eq("idle_busy", {31'd0, busy},        32'd0);
      check_eq("idle_tick", {31'd0, period_tick}, 32'd0);
    end

    // Illegal divisors 1 and 0.
    cfg_valid = 1'b1;
    cfg_div   = 8'd1;
    step();
    cfg_valid = 1'b0;
    check_eq("ill1_err",  {31'd0, cfg_err}, 32'd1);
    check_eq("ill1_busy", {31'd0, busy},    32'd0);
    cfg_valid = 1'b1;
    cfg_div   = 8'd0;
    step();
    cfg_valid = 1'b0;
    check_eq("ill0_err", {31'd0, cfg_err}, 32'd1);
    enable = 1'b1;
    run_chk("ill12a", 1, 12, 0, 1'b1);
    enable = 1'b0;
    run_chk("ill12b", 11, 12, 1, 1'b1);
    step();
    check_eq("ill_stop_busy", {31'd0, busy},    32'd0);
    check_eq("ill_stop_out",  {31'd0, out_s},   32'd0);
    check_eq("ill_err_hold",  {31'd0, cfg_err}, 32'd1);

    // Divisor 2 clears the error and toggles every cycle.
    cfg_valid = 1'b1;
    cfg_div   = 8'd2;
    step();
    cfg_valid = 1'b0;
    check_eq("div2_err",  {31'd0, cfg_err}, 32'd0);
    check_eq("div2_busy", {31'd0, busy},    32'd0);
    enable = 1'b1;
    run_chk("div2", 6, 2, 0, 1'b1);
    enable = 1'b0;
    step();
    check_eq("div2_stop", {31'd0, busy}, 32'd0);

    // Load 9 on the same edge as enable: first period already uses 9.
    cfg_valid = 1'b1;
    cfg_div   = 8'd9;
    enable    = 1'b1;
    run_chk("div9a", 1, 9, 0, 1'b1);
    cfg_valid = 1'b0;
    run_chk("div9b", 17, 9, 1, 1'b1);

    // Offer 30 on a wrap edge: old ratio 9 runs one more period, in PEND.
    cfg_valid = 1'b1;
    cfg_div   = 8'd30;
    run_chk("wrapcfg", 1, 9, 18, 1'b0);
    cfg_valid = 1'b0;
    run_chk("pend9", 2, 9, 19, 1'b0);

    // Asynchronous reset in the high phase of PEND.
    check_eq("pre_rst_out", {31'd0, out_s}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("arst_out",  {31'd0, out_s},       32'd0);
    check_eq("arst_rdy",  {31'd0, cfg_ready},   32'd1);
    check_eq("arst_busy", {31'd0, busy},        32'd0);
    check_eq("arst_tick", {31'd0, period_tick}, 32'd0);
    #2;
    reset = 1'b0;
    run_chk("post_rst12", 13, 12, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sched_ctrl.md
Name: div_sched_ctrl

Overview:
Runtime-programmable 50%-duty clock divider controller. It replaces the fixed div-by-9/12/80 instances with one block whose divide ratio is loaded through a valid/ready handshake. Ratio changes are scheduled to take effect only at an output-period boundary, so `out` never glitches. It sits between the configuration master and the divided-clock consumers. It also supplies a per-period tick for downstream counters.

Parameters:
- CNT_W, 8, width of divisor and internal period counter; legal divisors are 2..2^CNT_W-1.
- DEF_DIV, 12, active divisor after reset; must satisfy 2 <= DEF_DIV <= 2^CNT_W-1.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- cfg_valid  in  1  new divisor offered.
- cfg_div  in  CNT_W  requested divisor.
- cfg_ready  out  1  block can accept a divisor this cycle.
- cfg_err  out  1  sticky: last offered divisor was illegal (< 2).
- busy  out  1  high in RUN and PEND.
- period_tick  out  1  one-cycle pulse on the first cycle of every output period.
- out  out  1  divided clock.

Behaviour:
- Reset (async, immediate) values:
  - Outputs: out=0, period_tick=0, busy=0, cfg_ready=1, cfg_err=0.
  - Internal: state=IDLE, cnt=0, div_act=DEF_DIV, div_pend=0.
- States:
  - IDLE: stopped, out=0.
  - RUN: dividing.
  - PEND: dividing, with a new divisor waiting in div_pend.
- Counter and output, all registered on the clk rising edge:
  - In RUN/PEND, cnt steps 0..div_act-1 and then wraps to 0.
  - out_pos = (cnt < floor(div_act/2)).
  - period_tick = 1 exactly when cnt == 0 in RUN/PEND.
- Even N: out is high N/2 cycles and low N/2 cycles.
- Start:
  - IDLE with enable=1 at an edge: next state RUN, cnt=0, out=1, period_tick=1.
  - So the first high phase begins 1 cycle after enable is sampled.
- Stop:
  - enable=0 in RUN/PEND does not truncate the period.
  - At the wrap edge (cnt == div_act-1) the block goes to IDLE, out=0, cnt=0.
  - A pending divisor is applied at that same edge.
- Handshake:
  - A transfer occurs when cfg_valid && cfg_ready at a rising edge.
  - cfg_ready = (state != PEND).
  - Illegal cfg_div (0 or 1): consumed, cfg_err=1, no state change.
  - A legal transfer clears cfg_err.
  - Legal transfer in IDLE: div_act=cfg_div at that edge.
  - Legal transfer in RUN: div_pend=cfg_div, state=PEND, cfg_ready drops on the next cycle.
- PEND:
  - At the wrap edge, div_act=div_pend and cnt=0.
  - State becomes RUN if enable=1, else IDLE.
  - cfg_ready returns to 1 on the next cycle.
  - The new ratio's first period begins with that edge's period_tick.
- Simultaneous events:
  - Legal transfer in RUN on the wrap edge: the new divisor does not apply at that edge. It applies at the following wrap.
  - Transfer in IDLE on the same edge as enable=1: the new divisor applies to the very first period.
- Reset mid-operation forces all reset values at once; any pending divisor is lost.
- Divisor 2: out toggles every cycle and period_tick is high every other cycle.

Optional Feature:
- Macro ODD_DUTY50_EN.
- Defined:
  - Adds a falling-edge flop that captures out_pos; out = out_pos | out_neg.
  - Odd N therefore gets an exact 50% duty: high N/2 cycles, including the extra half cycle.
  - Even N: out_neg is masked (forced 0), so output is identical to the undefined build.
  - out_neg resets asynchronously to 0.
- Undefined:
  - No negedge logic.
  - Odd N gives high for (N-1)/2 cycles and low for (N+1)/2 cycles.

Test Plan:
- Reset, then enable=1 with no configuration:
  - out repeats 6 high / 6 low (DEF_DIV=12).
  - period_tick every 12 cycles.
  - busy=1.
- In RUN, offer cfg_div=80 at cnt=3:
  - cfg_ready=0 until the wrap.
  - The 12-cycle period completes intact.
  - Then out is 40 high / 40 low and cfg_ready=1.
- cfg_div=9 loaded in IDLE, then enable:
  - Without ODD_DUTY50_EN: 4 high / 5 low.
  - With ODD_DUTY50_EN: 4.5 high / 4.5 low, measured in time units.
- Offer cfg_div=1, then cfg_div=0:
  - cfg_err=1 after each offer, ratio unchanged, out period still 12.
  - A following cfg_div=2 clears cfg_err; out toggles every cycle.
- Drop enable at cnt=2 of a 12-cycle period:
  - out finishes its period, then stays 0.
  - busy=0 after the wrap edge, and no more period_tick.
- Assert reset mid-high-phase while in PEND:
  - out=0 immediately, without waiting for clk.
  - cfg_ready=1.
  - After release and enable, the period is 12 (pending divisor discarded).
